// File: rtl/pio_ctrl_pkg.sv
// Shared register map, EDGESEL field layout and sequencing states for the edge-capturing PIO
// input controller.
package pio_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_EDGESEL = 2'd3;

    localparam int unsigned EDGESEL_FALL_LSB = 16;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: accepted ("stable") level and its rise/fall strobes.
// With PIO_DEBOUNCE_EN defined a new level must persist DEB_CYCLES cycles before acceptance.
module pio_debounce_bit
`ifdef PIO_DEBOUNCE_EN
#(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned CNT_W      = 16
)
`endif
(
    input  logic clk,
    input  logic reset_n,
    input  logic sync1_i,
    input  logic load_i,
    input  logic run_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    logic stable_q, stable_d;

`ifdef PIO_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            stable_d = sync1_i;
            cnt_d    = '0;
        end else if (run_i) begin
            if (sync1_i == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntMax) begin
                stable_d = sync1_i;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        stable_d = stable_q;
        if (load_i || run_i) begin
            stable_d = sync1_i;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable_d;
        end
    end

    // Strobes fire with the accepting edge; the initial load never counts as an edge.
    assign rise_o   = run_i & stable_d & ~stable_q;
    assign fall_o   = run_i & ~stable_d & stable_q;
    assign stable_o = stable_q;

endmodule

// File: rtl/pio_in_edge_irq_ctrl.sv
// Avalon-MM PIO input with synchroniser, optional debounce (PIO_DEBOUNCE_EN), per-bit edge
// capture and a maskable level interrupt.
module pio_in_edge_irq_ctrl
    import pio_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address_i,
    input  logic             chipselect_i,
    input  logic             write_n_i,
    input  logic [31:0]      writedata_i,
    output logic [31:0]      readdata_o,
    input  logic [WIDTH-1:0] in_port_i,
    output logic             irq_o
);

    logic [WIDTH-1:0] sync0_q, sync1_q;
    logic [WIDTH-1:0] stable, rise, fall, edge_set;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] sel_rise_q, sel_rise_d;
    logic [WIDTH-1:0] sel_fall_q, sel_fall_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             fill_q, fill_d;
    fsm_state_t       state_q, state_d;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata_i;

`ifndef PIO_DEBOUNCE_EN
    localparam int unsigned unused_deb_cfg = DEB_CYCLES + CNT_W;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= in_port_i;
            sync1_q <= sync0_q;
        end
    end

    // Hold off edge detection until the synchroniser carries real input values.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            S_FILL: begin
                if (fill_q) begin
                    state_d = S_LOAD;
                end else begin
                    fill_d = 1'b1;
                end
            end
            S_LOAD:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FILL;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit
`ifdef PIO_DEBOUNCE_EN
        #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        )
`endif
        u_deb (
            .clk      (clk),
            .reset_n  (reset_n),
            .sync1_i  (sync1_q[i]),
            .load_i   (state_q == S_LOAD),
            .run_i    (state_q == S_RUN),
            .stable_o (stable[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    assign wr_en    = chipselect_i & ~write_n_i;
    assign edge_set = (rise & sel_rise_q) | (fall & sel_fall_q);

    always_comb begin
        irqmask_d  = irqmask_q;
        sel_rise_d = sel_rise_q;
        sel_fall_d = sel_fall_q;
        edgecap_d  = edgecap_q;
        if (wr_en) begin
            case (address_i)
                ADDR_IRQMASK: irqmask_d = writedata_i[WIDTH-1:0];
                ADDR_EDGECAP: edgecap_d = edgecap_q & ~writedata_i[WIDTH-1:0];
                ADDR_EDGESEL: begin
                    sel_rise_d = writedata_i[WIDTH-1:0];
                    sel_fall_d = writedata_i[EDGESEL_FALL_LSB +: WIDTH];
                end
                default: ;
            endcase
        end
        // A new edge beats a simultaneous write-1-to-clear.
        edgecap_d = edgecap_d | edge_set;
    end

    always_comb begin
        readdata_d = '0;
        case (address_i)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default: begin
                readdata_d[WIDTH-1:0]                   = sel_rise_q;
                readdata_d[EDGESEL_FALL_LSB +: WIDTH]   = sel_fall_q;
            end
        endcase
    end

    assign irq_d = |(edgecap_q & irqmask_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= '0;
            sel_rise_q <= '0;
            sel_fall_q <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            sel_rise_q <= sel_rise_d;
            sel_fall_q <= sel_fall_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata_o = readdata_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq_ctrl.sv
// Directed bench for pio_in_edge_irq_ctrl; expected latencies follow PIO_DEBOUNCE_EN.
module tb_pio_in_edge_irq_ctrl;
    import pio_ctrl_pkg::*;

`ifdef PIO_DEBOUNCE_EN
    localparam int          ACC        = 10;   // 2 sync + 8 debounce cycles
    localparam logic [31:0] GLITCH_CAP = 32'h0;
`else
    localparam int          ACC        = 3;    // 2 sync + 1 cycle
    localparam logic [31:0] GLITCH_CAP = 32'h2;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [2:0]  in_port;
    logic        irq;
    logic [31:0] d;

    int n_checks = 0;
    int n_fail   = 0;

    pio_in_edge_irq_ctrl #(
        .WIDTH      (3),
        .DEB_CYCLES (8),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address_i    (address),
        .chipselect_i (chipselect),
        .write_n_i    (write_n),
        .writedata_i  (writedata),
        .readdata_o   (readdata),
        .in_port_i    (in_port),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        address    = a;
        writedata  = v;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        tick(1);
        v = readdata;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 3'b101;

        // 1: inputs high through reset, no spurious edge on release
        tick(3);
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(3);
        check_eq("data_before_load", readdata, 32'h0);
        tick(1);
        check_eq("data_after_load", readdata, 32'h5);
        rd(ADDR_EDGECAP, d); check_eq("rst_edgecap", d, 32'h0);
        rd(ADDR_IRQMASK, d); check_eq("rst_irqmask", d, 32'h0);
        rd(ADDR_EDGESEL, d); check_eq("rst_edgesel", d, 32'h0);
        check_eq("irq_after_release", {31'b0, irq}, 32'h0);
        wr(ADDR_DATA, 32'hffff_ffff);
        rd(ADDR_DATA, d); check_eq("data_write_ignored", d, 32'h5);

        // 2: bit0 rise captured with exact latency, irq follows, W1C clears
        in_port = 3'b000;
        tick(ACC + 2);
        rd(ADDR_DATA, d); check_eq("data_zero", d, 32'h0);
        wr(ADDR_EDGESEL, 32'h1);
        wr(ADDR_IRQMASK, 32'h1);
        rd(ADDR_EDGESEL, d); check_eq("edgesel_rb", d, 32'h1);
        address = ADDR_EDGECAP;
        in_port = 3'b001;
        tick(ACC);
        check_eq("cap_not_yet", readdata, 32'h0);
        check_eq("irq_not_yet", {31'b0, irq}, 32'h0);
        tick(1);
        check_eq("cap_rise0", readdata, 32'h1);
        check_eq("irq_rise0", {31'b0, irq}, 32'h1);
        wr(ADDR_EDGECAP, 32'h1);
        check_eq("irq_lag_on_clear", {31'b0, irq}, 32'h1);
        tick(1);
        check_eq("irq_cleared", {31'b0, irq}, 32'h0);
        check_eq("cap_cleared", readdata, 32'h0);

        // 3: short pulse on bit1
        wr(ADDR_EDGESEL, 32'h0007_0007);
        rd(ADDR_EDGESEL, d); check_eq("edgesel_both_rb", d, 32'h0007_0007);
        in_port = 3'b011;
        tick(5);
        in_port = 3'b001;
        tick(ACC + 4);
        rd(ADDR_DATA, d); check_eq("glitch_data", d, 32'h1);
        rd(ADDR_EDGECAP, d); check_eq("glitch_cap", d, GLITCH_CAP);
        wr(ADDR_EDGECAP, 32'h7);
        rd(ADDR_EDGECAP, d); check_eq("cap_clear_all", d, 32'h0);

        // 4: falling edge select on bit1, masking
        wr(ADDR_EDGESEL, 32'h0002_0000);
        wr(ADDR_IRQMASK, 32'h0);
        in_port = 3'b011;
        tick(ACC + 2);
        rd(ADDR_EDGECAP, d); check_eq("rise1_unselected", d, 32'h0);
        in_port = 3'b001;
        tick(ACC + 2);
        rd(ADDR_EDGECAP, d); check_eq("fall1_cap", d, 32'h2);
        check_eq("fall1_masked_irq", {31'b0, irq}, 32'h0);
        wr(ADDR_IRQMASK, 32'h2);
        check_eq("irq_unmask_lag", {31'b0, irq}, 32'h0);
        tick(1);
        check_eq("irq_unmasked", {31'b0, irq}, 32'h1);
        wr(ADDR_EDGECAP, 32'h7);
        tick(1);
        check_eq("irq_after_w1c", {31'b0, irq}, 32'h0);

        // 5: W1C coinciding with a new bit0 edge
        wr(ADDR_EDGESEL, 32'h1);
        wr(ADDR_IRQMASK, 32'h1);
        in_port = 3'b000;
        tick(ACC + 2);
        rd(ADDR_EDGECAP, d); check_eq("cap_pre_collide", d, 32'h0);
        in_port = 3'b001;
        tick(ACC - 1);
        wr(ADDR_EDGECAP, 32'h1);
        rd(ADDR_EDGECAP, d); check_eq("set_wins", d, 32'h1);
        check_eq("irq_set_wins", {31'b0, irq}, 32'h1);

        // 6: reset mid-debounce discards all state
        address = ADDR_DATA;
        in_port = 3'b101;
        tick(7);
        reset_n = 1'b0;
        #1;
        check_eq("irq_async_rst", {31'b0, irq}, 32'h0);
        check_eq("rd_async_rst", readdata, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check_eq("data_after_rerst", readdata, 32'h5);
        rd(ADDR_EDGECAP, d); check_eq("cap_after_rerst", d, 32'h0);
        rd(ADDR_IRQMASK, d); check_eq("mask_after_rerst", d, 32'h0);

        // Input-to-DATA latency and multi-bit capture
        wr(ADDR_EDGESEL, 32'h0007_0007);
        wr(ADDR_IRQMASK, 32'h7);
        address = ADDR_DATA;
        in_port = 3'b111;
        tick(ACC);
        check_eq("data_lat_early", readdata, 32'h5);
        check_eq("irq_lat_early", {31'b0, irq}, 32'h0);
        tick(1);
        check_eq("data_lat", readdata, 32'h7);
        check_eq("irq_lat", {31'b0, irq}, 32'h1);
        rd(ADDR_EDGECAP, d); check_eq("cap_rise1", d, 32'h2);
        in_port = 3'b000;
        tick(ACC + 2);
        rd(ADDR_EDGECAP, d); check_eq("cap_fall_all", d, 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
